// File: rtl/sparse_pkg.sv
// Shared constants and helpers for the 2:4 structured-sparse weight packer.
package sparse_pkg;

    localparam int GROUP     = 4;
    localparam int KEEP      = 2;
    localparam int BW_DEF    = 4;
    localparam int TOTAL_DEF = 16;
    localparam int NROW_DEF  = 8;
    localparam int NGROUP    = TOTAL_DEF / GROUP;

    // One extra bit so the most negative weight ranks above the most positive one.
    function automatic logic [16:0] wmag(input logic signed [15:0] w);
        logic signed [16:0] x;
        x = 17'(w);
        return x[16] ? 17'(-x) : 17'(x);
    endfunction

endpackage

// File: rtl/sparse_group_select.sv
// Picks the 2 largest-magnitude weights of a 4-weight group (lower index wins ties).
module sparse_group_select
    import sparse_pkg::*;
#(
    parameter int BW = BW_DEF
) (
    input  logic [GROUP*BW-1:0] grp_flat,
    output logic [KEEP*BW-1:0]  kept_flat,
    output logic [GROUP-1:0]    mask,
    output logic [1:0]          pruned
);

    logic signed [BW-1:0] w   [GROUP];
    logic [16:0]          mag [GROUP];
    int                   beat;
    int                   slot;

    always_comb begin
        kept_flat = '0;
        mask      = '0;
        pruned    = '0;
        beat      = 0;
        slot      = 0;
        for (int k = 0; k < GROUP; k++) begin
            w[k]   = grp_flat[k*BW +: BW];
            mag[k] = wmag(16'(w[k]));
        end
        // A weight is kept when fewer than KEEP others outrank it.
        for (int i = 0; i < GROUP; i++) begin
            beat = 0;
            for (int j = 0; j < GROUP; j++) begin
                if (j != i && (mag[j] > mag[i] || (mag[j] == mag[i] && j < i)))
                    beat = beat + 1;
            end
            mask[i] = (beat < KEEP);
        end
        for (int i = 0; i < GROUP; i++) begin
            if (mask[i]) begin
                if (slot == 0) kept_flat[0 +: BW] = w[i];
                else           kept_flat[BW +: BW] = w[i];
                slot = slot + 1;
            end else if (w[i] != '0) begin
                pruned = pruned + 2'd1;
            end
        end
    end

endmodule

// File: rtl/sparse_weight_packer.sv
// 2:4 sparse weight packer with a 2-entry output buffer and frame row counter.
// Optional prune statistics counter built when SPARSE_PACK_STATS_EN is defined.
module sparse_weight_packer
    import sparse_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int total = TOTAL_DEF,
    parameter int nnz   = TOTAL_DEF / 2,
    parameter int nrow  = NROW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dense_valid,
    output logic                dense_ready,
    input  logic [total*bw-1:0] dense_flat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [nnz*bw-1:0]   weights_flat,
    output logic [total-1:0]    weight_mask,
    output logic                load,
    output logic                out_last,
    output logic [15:0]         prune_cnt
);

    localparam int NGRP = total / GROUP;
    localparam int RW   = (nrow > 1) ? $clog2(nrow) : 1;

    logic [nnz*bw-1:0] packed_w;
    logic [total-1:0]  packed_m;
    logic [NGRP*2-1:0] pruned_all;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        sparse_group_select #(.BW(bw)) u_sel (
            .grp_flat  (dense_flat[g*GROUP*bw +: GROUP*bw]),
            .kept_flat (packed_w[g*KEEP*bw +: KEEP*bw]),
            .mask      (packed_m[g*GROUP +: GROUP]),
            .pruned    (pruned_all[g*2 +: 2])
        );
    end

    logic [nnz*bw-1:0] wts_q  [2];
    logic [nnz*bw-1:0] wts_d  [2];
    logic [total-1:0]  msk_q  [2];
    logic [total-1:0]  msk_d  [2];
    logic [1:0]        last_q, last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [RW-1:0]     row_q, row_d;
    logic              push, pop, row_is_last;

    assign dense_ready  = (count_q < 2'd2);
    assign out_valid    = (count_q != 2'd0);
    assign push         = dense_valid & dense_ready;
    assign pop          = out_valid & out_ready;
    assign load         = pop;
    assign weights_flat = wts_q[rd_ptr_q];
    assign weight_mask  = msk_q[rd_ptr_q];
    assign out_last     = out_valid & last_q[rd_ptr_q];
    assign row_is_last  = (row_q == RW'(nrow - 1));

    always_comb begin
        wts_d    = wts_q;
        msk_d    = msk_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        row_d    = row_q;
        count_d  = count_q;
        if (push) begin
            wts_d[wr_ptr_q]  = packed_w;
            msk_d[wr_ptr_q]  = packed_m;
            last_d[wr_ptr_q] = row_is_last;
            wr_ptr_d         = ~wr_ptr_q;
            row_d            = row_is_last ? '0 : row_q + RW'(1);
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wts_q    <= '{default: '0};
            msk_q    <= '{default: '0};
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            row_q    <= '0;
        end else begin
            wts_q    <= wts_d;
            msk_q    <= msk_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            row_q    <= row_d;
        end
    end

`ifdef SPARSE_PACK_STATS_EN
    logic [15:0] prune_q, prune_d;
    logic [15:0] row_pruned;
    logic [16:0] prune_sum;

    always_comb begin
        row_pruned = '0;
        for (int g = 0; g < NGRP; g++)
            row_pruned = row_pruned + 16'(pruned_all[g*2 +: 2]);
        prune_sum = {1'b0, prune_q} + {1'b0, row_pruned};
        prune_d   = prune_q;
        if (push) prune_d = prune_sum[16] ? 16'hFFFF : prune_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prune_q <= '0;
        else        prune_q <= prune_d;
    end

    assign prune_cnt = prune_q;
`else
    logic unused_pruned;
    assign unused_pruned = ^pruned_all;
    assign prune_cnt     = '0;
`endif

endmodule
